// File: rtl/fetch_ptr.sv
// fetch_ptr: per-core instruction fetch and data-pointer stage.
//
// Issues pipelined reads to a fixed-latency instruction memory, buffers the
// returns in a small FIFO so that stalls from the select stage lose nothing,
// executes RIGHT/LEFT pointer moves locally, squashes on branch redirect and
// stops the core when END is consumed.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   core_en       core enable from the select chain
//   stall         stall from select; holds the presented instruction
//   branch_en     taken-branch redirect from execute
//   branch_target redirect pc
//   imem_en       read request
//   imem_addr     read address (pc)
//   imem_data     read data, valid IMEM_LAT cycles after imem_en
//   ins           instruction to select (16'h0000 = NOP)
//   ptr           current data pointer
//   halted        core stopped (HALT state or core_en low)
//   stall_cycles  only with FETCH_PERF_EN defined: saturating count of cycles
//                 with a non-NOP instruction held by stall
//
// Optional feature macro: FETCH_PERF_EN.

module fetch_ptr #(
  parameter int unsigned IMEM_LAT   = 2,
  parameter logic [15:0] START_PC   = 16'h0000,
  parameter logic [15:0] START_PTR  = 16'h0000,
  parameter int unsigned FIFO_DEPTH = IMEM_LAT + 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        core_en,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  output logic        imem_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ins,
  output logic [15:0] ptr,
  output logic        halted
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int unsigned IdxW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(FIFO_DEPTH - 1);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [3:0] OpRight = 4'h3;
  localparam logic [3:0] OpLeft  = 4'h4;
  localparam logic [3:0] OpEnd   = 4'hA;

  logic [0:0]          state_q, state_d;
  logic [15:0]         pc_q, pc_d;
  logic [15:0]         ptr_q, ptr_d;
  logic [IMEM_LAT-1:0] vpipe_q, vpipe_d;
  logic [IdxW-1:0]     rd_idx_q, rd_idx_d;
  logic [IdxW-1:0]     wr_idx_q, wr_idx_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                ready_q;
  logic [15:0]         fifo_mem [FIFO_DEPTH];

  logic        run;
  logic        present;
  logic [15:0] head;
  logic [3:0]  head_op;
  logic [15:0] imm;
  logic        is_move;
  logic        is_end;
  logic        redirect;
  logic        consume;
  logic        end_take;
  logic        flush;
  logic        push_en;
  logic        issue;
  logic [7:0]  inflight;
  logic [7:0]  occupancy;

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  // Requests still travelling through the memory pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < IMEM_LAT; i++) begin
      inflight = inflight + 8'(vpipe_q[i]);
    end
  end

  assign occupancy = inflight + 8'(cnt_q);

  assign run      = (state_q == StRun);
  assign present  = run && (cnt_q != '0);
  assign head     = fifo_mem[rd_idx_q];
  assign head_op  = head[15:12];
  assign imm      = {4'h0, head[11:0]};
  assign is_move  = (head_op == OpRight) || (head_op == OpLeft);
  assign is_end   = (head_op == OpEnd);
  assign redirect = run && branch_en;

  // Pointer moves are never visible to select, so stall does not hold them.
  // END still retires with core_en low so a stopping core halts cleanly.
  assign consume  = present && !redirect &&
                    (is_move ? core_en : (!stall && (core_en || is_end)));
  assign end_take = consume && is_end;
  assign flush    = redirect || end_take;

  // Counting in-flight requests against free entries guarantees every return
  // has a slot, even while select stalls.
  assign issue    = run && ready_q && core_en && !redirect && !end_take &&
                    (occupancy < 8'(FIFO_DEPTH));
  assign push_en  = vpipe_q[IMEM_LAT-1] && !flush;

  assign imem_en   = issue;
  assign imem_addr = pc_q;
  assign ins       = (present && core_en && !is_move) ? head : 16'h0000;
  assign ptr       = ptr_q;
  assign halted    = (state_q == StHalt) || !core_en;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ptr_d    = ptr_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    vpipe_d  = '0;

    if (flush || (state_q == StHalt)) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      cnt_d    = '0;
    end else begin
      for (int i = 1; i < IMEM_LAT; i++) begin
        vpipe_d[i] = vpipe_q[i-1];
      end
      vpipe_d[0] = issue;
      if (push_en) wr_idx_d = next_idx(wr_idx_q);
      if (consume) rd_idx_d = next_idx(rd_idx_q);
      cnt_d = cnt_q + CntW'(push_en) - CntW'(consume);
    end

    if (redirect) begin
      pc_d = branch_target;
    end else if (issue) begin
      pc_d = pc_q + 16'd1;
    end

    if (consume && (head_op == OpRight)) begin
      ptr_d = ptr_q + imm;
    end else if (consume && (head_op == OpLeft)) begin
      ptr_d = ptr_q - imm;
    end

    if (end_take) state_d = StHalt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRun;
      pc_q     <= START_PC;
      ptr_q    <= START_PTR;
      vpipe_q  <= '0;
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ptr_q    <= ptr_d;
      vpipe_q  <= vpipe_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      // Keeps imem_en low during reset and the release cycle.
      ready_q  <= 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the indices and count.
  always_ff @(posedge clk) begin
    if (push_en) fifo_mem[wr_idx_q] <= imem_data;
  end

`ifdef FETCH_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stall && (ins != 16'h0000) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ptr.sv
// Self-checking bench for fetch_ptr with a fixed-latency memory model and a
// scoreboard of instructions expected to be handed to select.

module tb_fetch_ptr;

  localparam int unsigned Lat = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        core_en;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ins;
  logic [15:0] ptr;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  fetch_ptr #(
    .IMEM_LAT (Lat),
    .START_PC (16'h0000),
    .START_PTR(16'h0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .core_en      (core_en),
    .stall        (stall),
    .branch_en    (branch_en),
    .branch_target(branch_target),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .ins          (ins),
    .ptr          (ptr),
    .halted       (halted)
`ifdef FETCH_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Memory model: free-running, not reset, so stale returns really arrive.
  logic [15:0] mem [65536];
  logic        rv_q [Lat];
  logic [15:0] ra_q [Lat];

  always @(posedge clk) begin
    rv_q[0] <= imem_en;
    ra_q[0] <= imem_addr;
    for (int i = 1; i < Lat; i++) begin
      rv_q[i] <= rv_q[i-1];
      ra_q[i] <= ra_q[i-1];
    end
  end

  assign imem_data = rv_q[Lat-1] ? mem[ra_q[Lat-1]] : 16'hEEEE;

  int errors = 0;
  int checks = 0;
  int n_en;
  int n_pres;
  logic [31:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input logic [15:0] i, input logic [15:0] p);
    sb_q.push_back({i, p});
  endtask

  // Every instruction accepted by select is compared with the scoreboard.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (rst_n && !stall && !branch_en && (ins != 16'h0000)) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", {ins, ptr}, 32'h0000_0000);
      end else begin
        exp_v = sb_q.pop_front();
        check("sb_ins_ptr", {ins, ptr}, exp_v);
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    stall         = 1'b0;
    branch_en     = 1'b0;
    branch_target = 16'h0000;
    core_en       = 1'b1;
    sb_q.delete();
    repeat (2) @(posedge clk);
  endtask

  // Returns at the falling edge of the first issuing cycle.
  task automatic wait_issue(input string tag);
    int n = 0;
    @(negedge clk);
    while (!imem_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!imem_en) check({tag, "_issue_timeout"}, 32'(imem_en), 32'd1);
  endtask

  task automatic run_until_halt(input string tag);
    int n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, 32'(halted), 32'd1);
    check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic load_seq();
    mem[0] = 16'h1001;
    mem[1] = 16'h1002;
    mem[2] = 16'h1003;
    mem[3] = 16'h1004;
    mem[4] = 16'hA000;
  endtask

  task automatic expect_seq();
    expect_out(16'h1001, 16'h0000);
    expect_out(16'h1002, 16'h0000);
    expect_out(16'h1003, 16'h0000);
    expect_out(16'h1004, 16'h0000);
    expect_out(16'hA000, 16'h0000);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    core_en       = 1'b1;
    stall         = 1'b0;
    branch_en     = 1'b0;
    branch_target = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

    // Straight line program.
    mem[0] = 16'h1000;
    mem[1] = 16'h1000;
    mem[2] = 16'hA000;
    apply_reset();
    @(negedge clk);
    check("rst_imem_en", 32'(imem_en), 32'd0);
    check("rst_ins", 32'(ins), 32'h0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ptr", 32'(ptr), 32'h0);
    check("rst_pc", 32'(imem_addr), 32'h0);
    expect_out(16'h1000, 16'h0000);
    expect_out(16'h1000, 16'h0000);
    expect_out(16'hA000, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_issue("t1");
    check("t1_addr0", 32'(imem_addr), 32'h0);
    @(negedge clk);
    check("t1_en1", 32'(imem_en), 32'd1);
    check("t1_addr1", 32'(imem_addr), 32'h1);
    @(negedge clk);
    check("t1_en2", 32'(imem_en), 32'd1);
    check("t1_addr2", 32'(imem_addr), 32'h2);
    @(negedge clk);
    check("t1_en3", 32'(imem_en), 32'd0);
    check("t1_ins3", 32'(ins), 32'h1000);
    @(negedge clk);
    check("t1_ins4", 32'(ins), 32'h1000);
    @(negedge clk);
    check("t1_ins5", 32'(ins), 32'hA000);
    check("t1_halted5", 32'(halted), 32'd0);
    @(negedge clk);
    check("t1_halted6", 32'(halted), 32'd1);
    check("t1_ins6", 32'(ins), 32'h0);
    check("t1_en6", 32'(imem_en), 32'd0);
    // A redirect in HALT must not restart fetch.
    @(posedge clk);
    #1 branch_en = 1'b1;
    branch_target = 16'h0040;
    @(negedge clk);
    check("t1_halt_br_en", 32'(imem_en), 32'd0);
    @(posedge clk);
    #1 branch_en = 1'b0;
    @(negedge clk);
    check("t1_halt_br_en2", 32'(imem_en), 32'd0);
    check("t1_halt_stay", 32'(halted), 32'd1);
    check("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // Pointer moves.
    mem[0] = 16'h3005;
    mem[1] = 16'h4002;
    mem[2] = 16'h1000;
    mem[3] = 16'hA000;
    apply_reset();
    expect_out(16'h1000, 16'h0003);
    expect_out(16'hA000, 16'h0003);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_issue("t2");
    check("t2_ptr0", 32'(ptr), 32'h0);
    repeat (3) @(negedge clk);
    check("t2_ins_right", 32'(ins), 32'h0);
    @(negedge clk);
    check("t2_ins_left", 32'(ins), 32'h0);
    check("t2_ptr_right", 32'(ptr), 32'h5);
    @(negedge clk);
    check("t2_ptr_left", 32'(ptr), 32'h3);
    check("t2_ins_plus", 32'(ins), 32'h1000);
    run_until_halt("t2");

    // Long stall: head held, fetch throttled, order preserved.
    load_seq();
    apply_reset();
    expect_seq();
    stall = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    n_en   = 0;
    n_pres = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (imem_en) n_en++;
      if (ins != 16'h0000) begin
        n_pres++;
        check("t3_hold", 32'(ins), 32'h1001);
      end
    end
    check("t3_issue_count", 32'(n_en), 32'd3);
    check("t3_pres_cycles", 32'(n_pres >= 5), 32'd1);
    @(posedge clk);
    #1 stall = 1'b0;
    run_until_halt("t3");

    // Branch with two requests in flight.
    mem[16'h0040] = 16'h1040;
    mem[16'h0041] = 16'hA000;
    apply_reset();
    expect_out(16'h1040, 16'h0000);
    expect_out(16'hA000, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_issue("t4");
    @(negedge clk);
    @(posedge clk);
    #1 branch_en = 1'b1;
    branch_target = 16'h0040;
    @(posedge clk);
    #1 branch_en = 1'b0;
    @(negedge clk);
    check("t4_en", 32'(imem_en), 32'd1);
    check("t4_addr", 32'(imem_addr), 32'h0040);
    check("t4_ins_b1", 32'(ins), 32'h0);
    @(negedge clk);
    check("t4_ins_b2", 32'(ins), 32'h0);
    run_until_halt("t4");

    // Pointer and pc wrap-around.
    mem[16'hFFFF] = 16'h4002;
    mem[0] = 16'h3003;
    mem[1] = 16'h1000;
    mem[2] = 16'hA000;
    mem[3] = 16'h0000;
    mem[4] = 16'h0000;
    apply_reset();
    expect_out(16'h1000, 16'h0001);
    expect_out(16'hA000, 16'h0001);
    @(posedge clk);
    #1 rst_n = 1'b1;
    branch_en = 1'b1;
    branch_target = 16'hFFFF;
    @(posedge clk);
    #1 branch_en = 1'b0;
    wait_issue("t5");
    check("t5_addr_ffff", 32'(imem_addr), 32'hFFFF);
    @(negedge clk);
    check("t5_en_wrap", 32'(imem_en), 32'd1);
    check("t5_addr_wrap", 32'(imem_addr), 32'h0000);
    repeat (2) @(negedge clk);
    check("t5_ins_left", 32'(ins), 32'h0);
    @(negedge clk);
    check("t5_ptr_fffe", 32'(ptr), 32'hFFFE);
    @(negedge clk);
    check("t5_ptr_wrap", 32'(ptr), 32'h0001);
    check("t5_ins_plus", 32'(ins), 32'h1000);
    run_until_halt("t5");

    // Reset pulse with two buffered entries and a return still in flight.
    load_seq();
    apply_reset();
    stall = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_issue("t6");
    repeat (3) @(negedge clk);
    check("t6_pre_ins", 32'(ins), 32'h1001);
    @(posedge clk);
    #1 rst_n = 1'b0;
    stall = 1'b0;
    sb_q.delete();
    #2;
    check("t6_rst_ins", 32'(ins), 32'h0);
    check("t6_rst_pc", 32'(imem_addr), 32'h0000);
    check("t6_rst_en", 32'(imem_en), 32'd0);
    #1 rst_n = 1'b1;
    expect_seq();
    wait_issue("t6b");
    check("t6_restart_addr", 32'(imem_addr), 32'h0000);
    run_until_halt("t6");

    // core_en low: no fetch, halted reported, then resume.
    apply_reset();
    core_en = 1'b0;
    expect_seq();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t7_off_en", 32'(imem_en), 32'd0);
      check("t7_off_halted", 32'(halted), 32'd1);
    end
    @(posedge clk);
    #1 core_en = 1'b1;
    @(negedge clk);
    check("t7_on_halted", 32'(halted), 32'd0);
    run_until_halt("t7");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ptr.md
Name: fetch_ptr

Overview:
- Per-core instruction fetch and data-pointer stage.
- Sits directly upstream of the register-select stage and drives that stage's ins/ptr inputs.
- Issues pipelined reads to a fixed-latency instruction memory and buffers returns so that stalls from select lose nothing.
- Executes RIGHT/LEFT pointer moves locally; squashes on branch redirect; stops the core on END.

Parameters:
IMEM_LAT, 2, instruction-memory read latency in cycles (1..4)
START_PC, 16'h0000, pc after reset
START_PTR, 16'h0000, data pointer after reset
FIFO_DEPTH, IMEM_LAT+1, return-buffer entries

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
core_en  in  1  core enable from the select chain's core_en_out
stall  in  1  stall from select; holds the presented instruction
branch_en  in  1  taken-branch redirect from execute
branch_target  in  16  redirect pc
imem_en  out  1  read request
imem_addr  out  16  read address (pc)
imem_data  in  16  read data, valid exactly IMEM_LAT cycles after imem_en
ins  out  16  instruction to select; 16'h0000 = NOP
ptr  out  16  current data pointer
halted  out  1  core stopped

Behaviour:
- Opcode field is ins[15:12]; imm is ins[11:0], zero-extended to 16 bits.
  - 0 NOP, 1 PLUS, 2 MINUS, 3 RIGHT, 4 LEFT, 5 BRZ, 9 PRINT, A END.
- Reset (async assert, sync release):
  - pc=START_PC, ptr=START_PTR, FIFO empty, in-flight valid pipe cleared.
  - state=RUN, imem_en=0, ins=0000, halted=0.
- States:
  - RUN: fetching.
  - HALT: terminal until reset.
- Issue:
  - In RUN, with core_en=1 and (in-flight count + FIFO count) < FIFO_DEPTH: imem_en=1, imem_addr=pc, pc<=pc+1 (mod 2^16).
  - At most one request per cycle.
  - A valid-bit shift register of length IMEM_LAT tracks requests. A return with its valid bit set is pushed to the FIFO.
- Present: ins = FIFO head when FIFO non-empty and state=RUN; otherwise 0000.
- Consume: the head is consumed in a cycle where it is presented, stall=0 and branch_en=0.
  - RIGHT: ptr<=ptr+imm (mod 2^16); ins is presented as 0000 in that cycle.
  - LEFT: ptr<=ptr-imm (mod 2^16); ins is presented as 0000 in that cycle.
  - The new ptr is visible the next cycle.
  - RIGHT/LEFT are never stalled by select; they are consumed in 1 cycle.
  - All other opcodes are presented verbatim with the current ptr.
  - END: when consumed, go to HALT. Flush the FIFO, clear the valid pipe, set halted=1 next cycle, imem_en=0.
- Stall: ins, ptr and FIFO head are held stable. Returns that arrive during the stall are still accepted (no overflow, by the issue rule).
- Branch (branch_en=1 in RUN):
  - pc<=branch_target, FIFO flushed, valid pipe cleared (late returns dropped), head not consumed, ptr unchanged.
  - First new request issues the next cycle.
  - Redirected instruction is presented no earlier than IMEM_LAT+1 cycles after branch_en.
- Simultaneous events:
  - branch_en beats stall.
  - branch_en in HALT is ignored.
  - core_en=0: no issue, ins=0000, halted=1 while low. In-flight returns are still buffered. Resumes in RUN when core_en returns to 1.
  - core_en=0 together with a presented END: END consumption still proceeds.
- Reset mid-operation: all state is cleared immediately; memory returns after release are ignored.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - Adds output stall_cycles (16 bits), which counts cycles where ins!=0000 and stall=1.
  - Saturates at FFFF; reset to 0.
- Undefined: the port and the counter are absent.

Test Plan:
- Straight line, IMEM_LAT=2, mem[0..2]=1000,1000,A000, no stall -> imem_en at cycles 0,1,2; ins 1000 at cycles 3 and 4, A000 at cycle 5; halted=1 at cycle 6.
- mem[0]=3005, mem[1]=4002, mem[2]=1000 -> ptr 0000->0005->0003; 1000 presented with ptr=0003; ins=0000 on the RIGHT/LEFT cycles.
- stall held high for 5 cycles while 1000 is presented -> ins held at 1000; FIFO reaches 3 entries, no further imem_en; order preserved after release.
- branch_en with target 0040 while 2 requests are in flight -> their returns are dropped; next imem_addr=0040; first ins is mem[0x40].
- ptr=FFFE plus RIGHT 0003 -> ptr=0001; pc=FFFF increments to 0000.
- rst_n pulsed low mid-stream with FIFO holding 2 entries -> ins=0000, pc=START_PC, stale return ignored; fetch restarts at START_PC.
